// File: rtl/reg_hazard_scoreboard_if.sv
// Decode-stage scoreboard bundle.
// The decode/control side drives the instruction fields and pipeline controls.
// The scoreboard returns the stall/issue decision, the pending-write mask and the stall counter.
interface reg_hazard_scoreboard_if;
    logic        id_valid;
    logic [2:0]  id_rs_sel;
    logic        id_rs_use;
    logic [2:0]  id_rt_sel;
    logic        id_rt_use;
    logic        id_wr_en;
    logic [2:0]  id_wr_sel;
    logic        mem_stall;
    logic        flush;
    logic        stall_clr;
    logic        stall;
    logic        issue;
    logic [7:0]  busy_mask;
    logic [15:0] stall_cnt;

    // Decode/control side.
    modport master (
        output id_valid, id_rs_sel, id_rs_use, id_rt_sel, id_rt_use,
        output id_wr_en, id_wr_sel, mem_stall, flush, stall_clr,
        input  stall, issue, busy_mask, stall_cnt
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, id_rs_sel, id_rs_use, id_rt_sel, id_rt_use,
        input  id_wr_en, id_wr_sel, mem_stall, flush, stall_clr,
        output stall, issue, busy_mask, stall_cnt
    );
endinterface

// File: rtl/reg_hazard_scoreboard.sv
// Register hazard scoreboard and stall controller for the decode stage.
// DEPTH slots mirror the EX..WB pipeline. Slot 0 is EX and slot DEPTH-1 is write-back.
// A register stays busy while any valid slot names it as destination.
// The RF has no bypass, so a consumer may issue only once the producer has left WB.
module reg_hazard_scoreboard #(
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_hazard_scoreboard_if.slave sb
);

    // Slot state: valid bit plus destination register per pipeline stage.
    logic [DEPTH-1:0] slot_vld_q;
    logic [DEPTH-1:0] slot_vld_d;
    logic [2:0]       slot_dst_q [DEPTH];
    logic [2:0]       slot_dst_d [DEPTH];

    logic [15:0]      stall_cnt_q;
    logic [15:0]      stall_cnt_d;

    logic [7:0]       busy_mask;
    logic             rs_hit;
    logic             rt_hit;
    logic             hazard;
    logic             stall;
    logic             issue;

    // Per-register busy decode: OR of every valid slot whose destination matches.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_busy
            logic [DEPTH-1:0] hit;
            for (gj = 0; gj < DEPTH; gj++) begin : g_slot
                assign hit[gj] = slot_vld_q[gj] && (slot_dst_q[gj] == 3'(gi));
            end
            assign busy_mask[gi] = |hit;
        end
    endgenerate

    // The decoded instruction's own destination is never compared.
    // It only enters slot 0 when it issues, so an instruction cannot stall on itself.
    assign rs_hit = sb.id_rs_use && busy_mask[sb.id_rs_sel];
    assign rt_hit = sb.id_rt_use && busy_mask[sb.id_rt_sel];

    // A flushed instruction is dead, so it can neither raise a hazard nor issue.
    assign hazard = sb.id_valid && !sb.flush && (rs_hit || rt_hit);

    // The memory freeze holds decode regardless of any hazard.
    // Reset forces the outputs low immediately.
    assign stall  = !rst && (sb.mem_stall || hazard);
    assign issue  = !rst && sb.id_valid && !sb.flush && !stall;

    assign sb.stall     = stall;
    assign sb.issue     = issue;
    assign sb.busy_mask = busy_mask;
    assign sb.stall_cnt = stall_cnt_q;

    // Slot next state. The slots shift one stage per unfrozen cycle and the WB entry drops off the end.
    // Slot 0 takes the issuing writer, or a bubble on a stall or flush.
    always_comb begin
        slot_vld_d = slot_vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            slot_dst_d[i] = slot_dst_q[i];
        end
        if (!sb.mem_stall) begin
            for (int i = 1; i < DEPTH; i++) begin
                slot_vld_d[i] = slot_vld_q[i-1];
                slot_dst_d[i] = slot_dst_q[i-1];
            end
            slot_vld_d[0] = issue && sb.id_wr_en;
            slot_dst_d[0] = sb.id_wr_sel;
        end
    end

    // Stall counter next state.
    // Only hazard cycles that are not frozen are counted, and the count saturates.
    // A clear wins over an increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (sb.stall_clr) begin
            stall_cnt_d = 16'h0000;
        end else if (hazard && !sb.mem_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end
    end

    // State registers. Reset empties the scoreboard at once, so all pending writes are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q  <= '0;
            stall_cnt_q <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                slot_dst_q[i] <= 3'd0;
            end
        end else begin
            slot_vld_q  <= slot_vld_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_dst_q[i] <= slot_dst_d[i];
            end
        end
    end

endmodule

// File: doc/reg_hazard_scoreboard.md
# reg_hazard_scoreboard

Scoreboard and stall controller for the decode stage of the 16-bit, 8-register pipelined core. It tracks the destination register of every in-flight instruction between decode and register-file write-back. It holds the instruction in decode whenever a source register it reads has a write still pending. The register file has no write-to-read bypass, so a register is busy until the cycle after its write-back completes. The block also counts stall cycles for performance debug.

## Interface
Parameters:
- DEPTH, 3, number of pipeline slots between decode and RF write (EX, MEM, WB); slot DEPTH-1 is the write-back slot.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high; clears all state.
- id_valid  input  1  a real instruction is present in decode.
- id_rs_sel  input  3  first source register (Instr[10:8]).
- id_rs_use  input  1  instruction reads id_rs_sel.
- id_rt_sel  input  3  second source register (Instr[7:5]).
- id_rt_use  input  1  instruction reads id_rt_sel.
- id_wr_en  input  1  instruction writes the register file.
- id_wr_sel  input  3  destination register (already muxed per RegDst, incl. R7).
- mem_stall  input  1  downstream freeze (memory not ready).
- flush  input  1  kill the instruction in decode (taken branch/jump).
- stall_clr  input  1  synchronous clear of stall_cnt.
- stall  output  1  hold fetch/decode this cycle.
- issue  output  1  decode instruction advances to EX this cycle.
- busy_mask  output  8  bit r set if register r has a pending write.
- stall_cnt  output  16  saturating count of hazard-stall cycles.

## Operation
- State: DEPTH slots, each {valid, dest[2:0]}; slot 0 = EX, slot DEPTH-1 = WB.
- busy_mask = OR over valid slots of onehot(dest).
- hazard = id_valid & ~flush & ((id_rs_use & busy_mask[id_rs_sel]) | (id_rt_use & busy_mask[id_rt_sel])).
- stall = ~rst & (mem_stall | hazard).
- issue = ~rst & id_valid & ~flush & ~stall.
- Slot update when mem_stall=0:
  - slot[i+1] <= slot[i] for each i.
  - The old WB slot retires.
  - slot 0 <= {issue & id_wr_en, id_wr_sel}.
  - A hazard stall or flush therefore inserts a bubble while older slots keep draining.
- Slot update when mem_stall=1: all slots hold; no bubble, no retire.
- An instruction's own destination never stalls itself: comparison is only against slots, never against id_wr_sel.
- Writes to R7 (JAL) and to any other register are tracked identically; no register is exempt.
- stall_cnt:
  - Increments by 1 on each cycle with hazard=1 and mem_stall=0.
  - Saturates at 16'hFFFF.
  - stall_clr has priority over increment and sets the count to 0.
- Priorities:
  - flush over hazard: a flushed instruction never stalls and never issues.
  - mem_stall over everything for slot movement.
  - flush with mem_stall: stall=1, issue=0, slots frozen.

## Timing
- stall, issue and busy_mask are combinational from the current inputs and slot state, valid in the same cycle; no added latency.
- A producer issued at edge t occupies slots after edges t..t+DEPTH-1 and retires at edge t+DEPTH.
- Back-to-back dependent instructions (no mem_stall) see exactly DEPTH (3) hazard-stall cycles. The consumer issues in the cycle after the producer's WB cycle.
- One independent instruction between producer and consumer reduces the stall to DEPTH-1 cycles, and so on. A gap of DEPTH or more gives 0 stall cycles.
- Reset values (asserted asynchronously, immediately on rst):
  - All slots invalid and busy_mask=0.
  - stall=0, issue=0, stall_cnt=0.
- Reset mid-operation discards all pending writes; the first cycle after release sees an empty scoreboard.
- Both sources matching the same busy slot, or different busy slots: still a single stall condition; stall_cnt increments once per cycle.

## Test plan
- Reset then idle, id_valid=0 -> busy_mask=8'h00, stall=0, issue=0, stall_cnt=0.
- Issue write R3; next cycle decode reads R3 (id_rs_use=1) -> stall=1 for exactly 3 cycles, busy_mask=8'h08 during them, issue=1 on the 4th cycle, stall_cnt=3.
- Write R1, independent op, then read R1 as rt -> 2 stall cycles. With 3 independent ops between producer and consumer -> 0 stalls.
- Write R2 followed by a dependent read of R2 under hazard, with mem_stall=1 for 2 cycles mid-hazard -> slots frozen, busy_mask held at 8'h04, total stall 5 cycles, stall_cnt=3.
- Hazard on R7 (JAL then read R7) with flush=1 in the first stall cycle -> stall=0 and issue=0 that cycle, no extra slot entry, R7 still retires on schedule.
- Assert rst while busy_mask=8'h30 -> busy_mask=0 immediately. Also, stall_cnt preloaded to 16'hFFFF by sustained stalls must not wrap; stall_clr=1 sets it to 0.
